pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Registered program-counter sequencer for the MIPS datapath. It replaces the open-coded PC register, PC+4 adder and branch/jump/jr mux chain with one block. The block is parametrised in address width and reset vector. It adds a valid/ready fetch handshake, a halt/resume state machine and a saturating redirect counter. It sits between the control/ALU outputs and instruction memory; decode consumes `pc`/`pc_plus_4` when the handshake fires.

## Interface
Parameters:
- WIDTH, 32, PC/address width in bits (≥ JUMP_BITS+3)
- RESET_VECTOR, 0, PC value loaded on reset (word aligned)
- JUMP_BITS, 26, width of the J-type index field
- CNT_BITS, 16, width of redirect counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- out_valid  out  1  `pc` holds a fetch address to be consumed
- out_ready  in  1  consumer accepts `pc` this cycle
- pc  out  WIDTH  current fetch address
- pc_plus_4  out  WIDTH  `pc + 4`, mod 2^WIDTH, combinational from `pc`
- branch_taken  in  1  instruction at `pc` is a taken branch
- branch_offset  in  WIDTH  sign-extended word offset
- jump  in  1  instruction at `pc` is j/jal
- jump_index  in  JUMP_BITS  J-type index field
- jr  in  1  instruction at `pc` is jr
- jr_target  in  WIDTH  register-file read data 1
- halt_req  in  1  request halt
- resume  in  1  leave HALT
- halted  out  1  in HALT state
- redirect_count  out  CNT_BITS  saturating count of non-sequential PC updates

## Operation
- fire = out_valid & out_ready. Redirect inputs are sampled only on fire and are ignored otherwise.
- Next PC on fire, in priority order:
  - jr → jr_target
  - jump → {pc_plus_4[WIDTH-1:JUMP_BITS+2], jump_index, 2'b00}
  - branch_taken → pc_plus_4 + (branch_offset << 2)
  - otherwise → pc_plus_4
- All arithmetic is truncated to WIDTH bits, so wrap-around is silent. For example, pc = 2^WIDTH−4 advances to 0.
- jr_target is loaded unmodified; misalignment is not checked.
- States:
  - IDLE: out_valid=0 for exactly one cycle after reset, then go to RUN.
  - RUN: out_valid=1.
    - halt_req & fire: PC advances, go to HALT.
    - halt_req & !fire: PC holds, go to HALT. The unconsumed instruction is re-presented after resume.
    - resume in RUN is ignored.
  - HALT: out_valid=0, halted=1, PC holds.
    - resume: go to RUN next cycle.
    - halt_req in HALT is ignored. halt_req & resume together in HALT → RUN.
- redirect_count increments on each fire whose next PC came from jr, jump or branch_taken. It holds at 2^CNT_BITS−1 and does not wrap.
- Reset values: pc=RESET_VECTOR, state IDLE, out_valid=0, halted=0, redirect_count=0. pc_plus_4=RESET_VECTOR+4.

## Timing
- pc, state, halted and redirect_count are registered and update on the rising clk edge following the sampling cycle.
- Single-cycle issue: back-to-back fires advance pc every cycle.
- Redirect latency is 1 cycle. The target appears on `pc` the cycle after the fire that sampled it; there is no bubble.
- While out_valid=1 & !out_ready, pc and out_valid hold stable (no retraction).
- Halt latency: halted=1 the cycle after halt_req is sampled in RUN.
- Resume latency: out_valid=1 the cycle after resume is sampled in HALT.
- rst_n low forces reset values immediately, asynchronously, even mid-stall or mid-halt. Release is synchronous to the next edge, followed by one IDLE cycle.
- No combinational path from any input to out_valid or pc. pc_plus_4 depends only on pc.

## Test plan
- Reset, RESET_VECTOR=0x00400000, out_ready=1, no redirects → out_valid=0 one cycle, then pc = 0x00400000, 0x00400004, 0x00400008…; redirect_count stays 0.
- Same cycle: jr=1 (jr_target=0x1000), jump=1, branch_taken=1 at pc=0x40 → next pc=0x1000. Then jump=1, jump_index=0x0000010 at pc=0x1000 → next pc=0x40. Then branch_taken=1, branch_offset=0xFFFFFFFF at pc=0x40 → next pc=0x40. redirect_count=3.
- out_ready=0 for 3 cycles with branch_taken=1 held → pc stable, no count change. Then out_ready=1 → branch target loaded once, count +1.
- halt_req while out_ready=0 at pc=0x20 → halted=1, out_valid=0 next cycle. resume → pc=0x20 re-presented with out_valid=1.
- Wrap: WIDTH=32, jr_target=0xFFFFFFFC, then sequential fire → pc=0x00000000; pc_plus_4 at 0xFFFFFFFC = 0x00000000.
- Force redirect_count to saturate (CNT_BITS=4, 17 jumps) → holds 15. Assert rst_n low mid-HALT → immediate pc=RESET_VECTOR, halted=0, count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered MIPS program-counter sequencer: PC register, PC+4, jr/jump/branch
// redirect mux, valid/ready fetch handshake, halt/resume FSM, redirect counter.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               JUMP_BITS    = 26,
  parameter int               CNT_BITS     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus_4,
  input  logic                 branch_taken,
  input  logic [WIDTH-1:0]     branch_offset,
  input  logic                 jump,
  input  logic [JUMP_BITS-1:0] jump_index,
  input  logic                 jr,
  input  logic [WIDTH-1:0]     jr_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic                 halted,
  output logic [CNT_BITS-1:0]  redirect_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t              state, state_nxt;
  logic                fire;
  logic                redirect;
  logic [WIDTH-1:0]    pc_nxt;
  logic [WIDTH-1:0]    jump_tgt;
  logic [WIDTH-1:0]    branch_tgt;
  logic [CNT_BITS-1:0] cnt_nxt;

  // Outputs decode straight from registers: no input reaches out_valid or pc.
  assign out_valid = (state == S_RUN);
  assign halted    = (state == S_HALT);
  assign fire      = out_valid & out_ready;

  assign pc_plus_4  = pc + WIDTH'(4);
  assign jump_tgt   = {pc_plus_4[WIDTH-1:JUMP_BITS+2], jump_index, 2'b00};
  assign branch_tgt = pc_plus_4 + (branch_offset << 2);

  always_comb begin
    pc_nxt   = pc;
    redirect = 1'b0;
    if (fire) begin
      redirect = jr | jump | branch_taken;
      if (jr)                pc_nxt = jr_target;
      else if (jump)         pc_nxt = jump_tgt;
      else if (branch_taken) pc_nxt = branch_tgt;
      else                   pc_nxt = pc_plus_4;
    end
  end

  always_comb begin
    cnt_nxt = redirect_count;
    if (redirect && redirect_count != '1) cnt_nxt = redirect_count + CNT_BITS'(1);
  end

  // A halt with no fire leaves pc untouched, so the stalled fetch is re-presented.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_RUN;
      S_RUN:   if (halt_req) state_nxt = S_HALT;
      S_HALT:  if (resume)   state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_VECTOR;
      redirect_count <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      redirect_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic,
// compared against an arithmetic reference model.
module tb_pc_sequencer;
  localparam int          W   = 32;
  localparam int          JB  = 26;
  localparam int          CB  = 4;
  localparam logic [31:0] RV  = 32'h0040_0000;
  localparam longint      MOD = 64'h1_0000_0000;
  localparam int          P_IDLE = 0, P_RUN = 1, P_HALT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [W-1:0]  pc, pc_plus_4;
  logic          branch_taken = 1'b0;
  logic [W-1:0]  branch_offset = '0;
  logic          jump = 1'b0;
  logic [JB-1:0] jump_index = '0;
  logic          jr = 1'b0;
  logic [W-1:0]  jr_target = '0;
  logic          halt_req = 1'b0, resume = 1'b0;
  logic          halted;
  logic [CB-1:0] redirect_count;

  pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV), .JUMP_BITS(JB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .pc_plus_4(pc_plus_4), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target), .halt_req(halt_req), .resume(resume),
    .halted(halted), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integers, one phase number per documented state.
  longint m_pc, m_cnt;
  int     m_phase;

  task automatic m_reset();
    m_pc = RV; m_cnt = 0; m_phase = P_IDLE;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},  out_valid,      m_phase == P_RUN);
    chk({tag, ".halted"}, halted,         m_phase == P_HALT);
    chk({tag, ".pc"},     pc,             m_pc);
    chk({tag, ".pc4"},    pc_plus_4,      (m_pc + 4) % MOD);
    chk({tag, ".cnt"},    redirect_count, m_cnt);
  endtask

  // Drive one cycle's inputs from the negedge, advance the model, check at the next negedge.
  task automatic tick(input string tag, input bit rdy, input bit br, input logic [31:0] off,
                      input bit jmp, input logic [JB-1:0] idx, input bit jri,
                      input logic [31:0] jrt, input bit hq, input bit rs);
    longint seq, nxt, n_cnt;
    int     n_phase;
    bit     fire;
    out_ready = rdy; branch_taken = br; branch_offset = off; jump = jmp;
    jump_index = idx; jr = jri; jr_target = jrt; halt_req = hq; resume = rs;
    fire    = (m_phase == P_RUN) && rdy;
    seq     = (m_pc + 4) % MOD;
    nxt     = m_pc;
    n_cnt   = m_cnt;
    n_phase = m_phase;
    if (fire) begin
      if (jri)     nxt = jrt;
      else if (jmp) nxt = (seq / (64'd1 << 28)) * (64'd1 << 28) + longint'(idx) * 4;
      else if (br)  nxt = (seq + longint'(off) * 4) % MOD;
      else          nxt = seq;
      if ((jri || jmp || br) && m_cnt < 15) n_cnt = m_cnt + 1;
    end
    case (m_phase)
      P_IDLE: n_phase = P_RUN;
      P_RUN:  if (hq) n_phase = P_HALT;
      default: if (rs) n_phase = P_RUN;
    endcase
    @(posedge clk);
    m_pc = nxt; m_cnt = n_cnt; m_phase = n_phase;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic seqc(input string tag, input bit rdy);
    tick(tag, rdy, 0, '0, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic go_jr(input string tag, input logic [31:0] t);
    tick(tag, 1, 0, '0, 0, '0, 1, t, 0, 0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Sequential fetch from the reset vector.
    for (int i = 0; i < 4; i++) seqc("seq", 1);

    // Priority: jr beats jump beats branch.
    go_jr("to40", 32'h40);
    tick("prio", 1, 1, 32'h4, 1, 26'h3, 1, 32'h1000, 0, 0);
    tick("jump", 1, 0, '0, 1, 26'h10, 0, '0, 0, 0);
    tick("brneg", 1, 1, 32'hFFFF_FFFF, 0, '0, 0, '0, 0, 0);

    // Stall with a held branch: nothing moves until the handshake fires.
    for (int i = 0; i < 3; i++) tick("stall", 0, 1, 32'h5, 0, '0, 0, '0, 0, 0);
    tick("stallgo", 1, 1, 32'h5, 0, '0, 0, '0, 0, 0);

    // Halt while stalled at 0x20, ignored halt_req in HALT, resume re-presents 0x20.
    go_jr("to20", 32'h20);
    tick("haltst", 0, 0, '0, 0, '0, 0, '0, 1, 0);
    tick("haltig", 1, 0, '0, 0, '0, 0, '0, 1, 0);
    tick("resume", 1, 0, '0, 0, '0, 0, '0, 1, 1);
    tick("resig", 0, 0, '0, 0, '0, 0, '0, 0, 1);
    seqc("after", 1);
    // Halt together with a fire advances the pc.
    tick("haltfire", 1, 0, '0, 0, '0, 0, '0, 1, 0);
    tick("resume2", 0, 0, '0, 0, '0, 0, '0, 0, 1);

    // Wrap-around at the top of the address space.
    go_jr("toTop", 32'hFFFF_FFFC);
    seqc("wrap", 1);

    // Saturate the redirect counter.
    for (int i = 0; i < 17; i++) tick("sat", 1, 0, '0, 1, JB'(i * 3), 0, '0, 0, 0);

    // Asynchronous reset in the middle of HALT.
    tick("halt3", 1, 0, '0, 0, '0, 0, '0, 1, 0);
    #2 rst_n = 1'b0;
    #1 m_reset();
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    seqc("post", 1);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] off, jrt;
      off = ($urandom_range(0, 1) != 0) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom;
      jrt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, off,
           $urandom_range(0, 5) == 0, JB'($urandom), $urandom_range(0, 7) == 0, jrt,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
